// File: rtl/pi_phase_ctrl_if.sv
// Bundle between the CDR loop filter (master) and the phase-interpolator code controller (slave).
// The mixer-facing code and decodes travel back on the same bundle.
interface pi_phase_ctrl_if #(
  parameter int FINE_W = 8,
  parameter int QUAD_W = 2,
  parameter int STEP_W = 4,
  parameter int DIV_W  = 4
);
  logic                       en;
  logic                       up;
  logic                       dn;
  logic [STEP_W-1:0]          step;
  logic [DIV_W-1:0]           upd_div;
  logic                       load;
  logic [QUAD_W+FINE_W-1:0]   load_code;
  logic [QUAD_W+FINE_W-1:0]   Code;
  logic [FINE_W-1:0]          weight_p2;
  logic [FINE_W-1:0]          weight_p1;
  logic [(1<<QUAD_W)-1:0]     phase_sel;
  logic                       busy;
  logic                       wrap_pulse;
  logic                       miss;

  modport master (
    output en, up, dn, step, upd_div, load, load_code,
    input  Code, weight_p2, weight_p1, phase_sel, busy, wrap_pulse, miss
  );

  modport slave (
    input  en, up, dn, step, upd_div, load, load_code,
    output Code, weight_p2, weight_p1, phase_sel, busy, wrap_pulse, miss
  );
endinterface

// File: rtl/pi_phase_ctrl.sv
// Phase-interpolator code controller: turns rate-divided up/dn decisions into a {quadrant, fine}
// mixer code, walking quadrant crossings through the equivalent-phase edge so the mixer never glitches.
module pi_phase_ctrl #(
  parameter int FINE_W        = 8,
  parameter int QUAD_W        = 2,
  parameter int STEP_W        = 4,
  parameter int DIV_W         = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic           CLK,
  input  logic           rst_n,
  pi_phase_ctrl_if.slave bus
);

  localparam int CODE_W = QUAD_W + FINE_W;
  localparam int NPH    = 1 << QUAD_W;
  localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam logic [QUAD_W-1:0] QMAX     = '1;
  localparam logic [CNT_W-1:0]  HOLD_END = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDGE   = 2'd1,
    SWAP   = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t             state;
  logic [CODE_W-1:0]  code;
  logic [CODE_W-1:0]  target;
  logic               dir_up;
  logic [CNT_W-1:0]   hold_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic               busy_r;
  logic               wrap_r;
  logic               miss_r;

  logic               tick;
  logic               req_nz;
  logic               req_up;
  logic [CODE_W-1:0]  tgt_nxt;
  logic               crosses;

  function automatic logic [QUAD_W-1:0] quad_of(input logic [CODE_W-1:0] c);
    return c[CODE_W-1:FINE_W];
  endfunction

  // Modular add/subtract of the step; the code space wraps through quadrant max -> 0.
  function automatic logic [CODE_W-1:0] step_code(input logic [CODE_W-1:0] c,
                                                  input logic [STEP_W-1:0] s,
                                                  input logic              inc);
    logic [CODE_W-1:0] s_ext;
    s_ext = CODE_W'(s);
    return inc ? (c + s_ext) : (c - s_ext);
  endfunction

  // Last fine position in the current quadrant before handing over to the neighbouring pair.
  function automatic logic [CODE_W-1:0] edge_code(input logic [QUAD_W-1:0] q,
                                                  input logic              inc);
    return inc ? {q, {FINE_W{1'b1}}} : {q, {FINE_W{1'b0}}};
  endfunction

  // Same physical phase as edge_code, expressed in the neighbouring quadrant.
  function automatic logic [CODE_W-1:0] equiv_code(input logic [QUAD_W-1:0] q,
                                                   input logic              inc);
    logic [QUAD_W-1:0] qn;
    qn = inc ? (q + QUAD_W'(1)) : (q - QUAD_W'(1));
    return inc ? {qn, {FINE_W{1'b0}}} : {qn, {FINE_W{1'b1}}};
  endfunction

  function automatic logic is_wrap(input logic [QUAD_W-1:0] q_old,
                                   input logic [QUAD_W-1:0] q_new);
    return ((q_old == QMAX) && (q_new == '0)) || ((q_old == '0) && (q_new == QMAX));
  endfunction

  always_comb begin
    tick    = bus.en && (div_cnt == bus.upd_div);
    req_up  = bus.up;
    req_nz  = tick && (bus.up ^ bus.dn) && (bus.step != '0);
    tgt_nxt = step_code(code, bus.step, req_up);
    crosses = (quad_of(tgt_nxt) != quad_of(code));
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      code     <= '0;
      target   <= '0;
      dir_up   <= 1'b0;
      hold_cnt <= '0;
      div_cnt  <= '0;
      busy_r   <= 1'b0;
      wrap_r   <= 1'b0;
      miss_r   <= 1'b0;
    end else begin
      div_cnt <= (!bus.en || tick) ? '0 : (div_cnt + DIV_W'(1));
      wrap_r  <= 1'b0;
      // A live request is dropped whenever it cannot act: mid-sequence or pre-empted by a load.
      miss_r  <= req_nz && (busy_r || bus.load);

      if (bus.load) begin
        code     <= bus.load_code;
        state    <= SETTLE;
        busy_r   <= 1'b1;
        hold_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (req_nz) begin
              if (!crosses) begin
                code <= tgt_nxt;
              end else begin
                code     <= edge_code(quad_of(code), req_up);
                target   <= tgt_nxt;
                dir_up   <= req_up;
                state    <= EDGE;
                busy_r   <= 1'b1;
                hold_cnt <= '0;
              end
            end
          end
          EDGE: begin
            if (hold_cnt == HOLD_END) begin
              code     <= equiv_code(quad_of(code), dir_up);
              wrap_r   <= is_wrap(quad_of(code), quad_of(equiv_code(quad_of(code), dir_up)));
              state    <= SWAP;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + CNT_W'(1);
            end
          end
          SWAP: begin
            if (hold_cnt == HOLD_END) begin
              code   <= target;
              state  <= IDLE;
              busy_r <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + CNT_W'(1);
            end
          end
          SETTLE: begin
            if (hold_cnt == HOLD_END) begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.Code       = code;
  assign bus.weight_p2  = code[FINE_W-1:0];
  assign bus.weight_p1  = ~code[FINE_W-1:0];
  assign bus.phase_sel  = NPH'(1) << quad_of(code);
  assign bus.busy       = busy_r;
  assign bus.wrap_pulse = wrap_r;
  assign bus.miss       = miss_r;

  a_busy_state: assert property (@(posedge CLK) disable iff (!rst_n)
    busy_r == (state != IDLE));
  a_sel_onehot: assert property (@(posedge CLK) disable iff (!rst_n)
    $onehot(bus.phase_sel));

endmodule

// File: tb/tb_pi_phase_ctrl.sv
// Directed bench for pi_phase_ctrl: expected outputs are queued when stimulus is applied and
// popped for comparison one clock later.
module tb_pi_phase_ctrl;

  localparam int FINE_W = 8;
  localparam int QUAD_W = 2;
  localparam int STEP_W = 4;
  localparam int DIV_W  = 4;
  localparam int SETTLE = 4;

  typedef struct {
    logic [9:0] code;
    logic       busy;
    logic       wrap;
    logic       miss;
  } exp_t;

  logic CLK;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];

  pi_phase_ctrl_if #(.FINE_W(FINE_W), .QUAD_W(QUAD_W), .STEP_W(STEP_W), .DIV_W(DIV_W)) bus ();

  pi_phase_ctrl #(
    .FINE_W(FINE_W), .QUAD_W(QUAD_W), .STEP_W(STEP_W), .DIV_W(DIV_W), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    logic [7:0] p2;
    logic [7:0] p1;
    logic [3:0] sel;
    logic [1:0] q;
    p2  = e.code[7:0];
    p1  = ~p2;
    q   = e.code[9:8];
    sel = 4'b0001 << q;
    chk({tag, ".code"}, 32'(bus.Code),       32'(e.code));
    chk({tag, ".wp2"},  32'(bus.weight_p2),  32'(p2));
    chk({tag, ".wp1"},  32'(bus.weight_p1),  32'(p1));
    chk({tag, ".sel"},  32'(bus.phase_sel),  32'(sel));
    chk({tag, ".busy"}, 32'(bus.busy),       32'(e.busy));
    chk({tag, ".wrap"}, 32'(bus.wrap_pulse), 32'(e.wrap));
    chk({tag, ".miss"}, 32'(bus.miss),       32'(e.miss));
  endtask

  // Queue the expectation for the coming edge, then compare once the edge has happened.
  task automatic step_exp(input string tag, input logic [9:0] c, input logic b,
                          input logic w, input logic m);
    exp_t e;
    sbq.push_back('{code: c, busy: b, wrap: w, miss: m});
    @(posedge CLK);
    #1;
    e = sbq.pop_front();
    chk_outputs(tag, e);
  endtask

  task automatic load_settle(input string tag, input logic [9:0] c, input logic m0);
    bus.load      = 1'b1;
    bus.load_code = c;
    step_exp(tag, c, 1'b1, 1'b0, m0);
    bus.load = 1'b0;
    bus.up   = 1'b0;
    bus.dn   = 1'b0;
    for (int i = 0; i < SETTLE - 1; i++) step_exp(tag, c, 1'b1, 1'b0, 1'b0);
    step_exp(tag, c, 1'b0, 1'b0, 1'b0);
  endtask

  // Caller has set direction/step; request is held for one update only.
  task automatic crossing(input string tag, input logic [9:0] edge_c, input logic [9:0] eq_c,
                          input logic [9:0] tgt, input logic wr);
    step_exp(tag, edge_c, 1'b1, 1'b0, 1'b0);
    bus.up = 1'b0;
    bus.dn = 1'b0;
    for (int i = 0; i < SETTLE - 1; i++) step_exp(tag, edge_c, 1'b1, 1'b0, 1'b0);
    step_exp(tag, eq_c, 1'b1, wr, 1'b0);
    for (int i = 0; i < SETTLE - 1; i++) step_exp(tag, eq_c, 1'b1, 1'b0, 1'b0);
    step_exp(tag, tgt, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    exp_t zero_e;
    zero_e = '{code: 10'h000, busy: 1'b0, wrap: 1'b0, miss: 1'b0};
    rst_n         = 1'b1;
    bus.en        = 1'b0;
    bus.up        = 1'b0;
    bus.dn        = 1'b0;
    bus.step      = '0;
    bus.upd_div   = '0;
    bus.load      = 1'b0;
    bus.load_code = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_outputs("reset", zero_e);
    rst_n = 1'b1;

    // fine stepping, one update per cycle
    bus.en      = 1'b1;
    bus.upd_div = 4'd0;
    bus.step    = 4'd1;
    bus.up      = 1'b1;
    for (int i = 1; i <= 10; i++) step_exp("fine", 10'(i), 1'b0, 1'b0, 1'b0);
    bus.up = 1'b0;

    // up crossing with the request held: every tick inside the busy window is a miss
    load_settle("ld0fe", 10'h0FE, 1'b0);
    bus.step = 4'd4;
    bus.up   = 1'b1;
    for (int i = 0; i < 4; i++) step_exp("upx", 10'h0FF, 1'b1, 1'b0, (i > 0));
    for (int i = 0; i < 4; i++) step_exp("upx", 10'h100, 1'b1, 1'b0, 1'b1);
    step_exp("upx", 10'h102, 1'b0, 1'b0, 1'b1);
    bus.up = 1'b0;
    step_exp("upx_end", 10'h102, 1'b0, 1'b0, 1'b0);

    // wrap max -> 0 going up
    load_settle("ld3fd", 10'h3FD, 1'b0);
    bus.step = 4'd4;
    bus.up   = 1'b1;
    crossing("wrap", 10'h3FF, 10'h000, 10'h001, 1'b1);

    // down crossing 1 -> 0
    load_settle("ld101", 10'h101, 1'b0);
    bus.step = 4'd3;
    bus.dn   = 1'b1;
    crossing("dnx", 10'h100, 10'h0FF, 10'h0FE, 1'b0);

    // rate divider: one update every 4 cycles
    load_settle("ld010", 10'h010, 1'b0);
    bus.upd_div = 4'd3;
    bus.step    = 4'd2;
    bus.up      = 1'b1;
    for (int e = 1; e <= 12; e++) step_exp("div", 10'h010 + 10'(2 * (e / 4)), 1'b0, 1'b0, 1'b0);

    // up and dn together: no change, no miss
    bus.dn      = 1'b1;
    bus.upd_div = 4'd0;
    for (int i = 0; i < 4; i++) step_exp("updn", 10'h016, 1'b0, 1'b0, 1'b0);

    // disabled: frozen
    bus.dn = 1'b0;
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) step_exp("en0", 10'h016, 1'b0, 1'b0, 1'b0);

    // load pre-empting a live tick from IDLE
    bus.en   = 1'b1;
    bus.step = 4'd8;
    bus.up   = 1'b1;
    load_settle("ld1fc", 10'h1FC, 1'b1);

    // load aborting a crossing in SWAP
    bus.up = 1'b1;
    step_exp("abort", 10'h1FF, 1'b1, 1'b0, 1'b0);
    bus.up = 1'b0;
    for (int i = 0; i < 3; i++) step_exp("abort", 10'h1FF, 1'b1, 1'b0, 1'b0);
    step_exp("abort", 10'h200, 1'b1, 1'b0, 1'b0);
    step_exp("abort", 10'h200, 1'b1, 1'b0, 1'b0);
    bus.load      = 1'b1;
    bus.load_code = 10'h2A0;
    bus.up        = 1'b1;
    step_exp("abort_ld", 10'h2A0, 1'b1, 1'b0, 1'b1);
    bus.load = 1'b0;
    bus.up   = 1'b0;
    for (int i = 0; i < 3; i++) step_exp("abort_ld", 10'h2A0, 1'b1, 1'b0, 1'b0);
    step_exp("abort_ld", 10'h2A0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset while parked in EDGE
    load_settle("ld2fc", 10'h2FC, 1'b0);
    bus.up = 1'b1;
    step_exp("edge", 10'h2FF, 1'b1, 1'b0, 1'b0);
    bus.up = 1'b0;
    step_exp("edge", 10'h2FF, 1'b1, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk_outputs("arst", zero_e);
    rst_n = 1'b1;
    step_exp("post_rst", 10'h000, 1'b0, 1'b0, 1'b0);
    step_exp("post_rst", 10'h000, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
